// File: rtl/vga_pkg.sv
// Shared timing constants and control-bit bundle for the VGA raster generator.
// Defaults describe 640x480 @ 60 Hz with a 25.175 MHz pixel tick.
package vga_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int unsigned VGA_CNT_W = 11;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank;
   } vga_ctrl_t;

   // Idle control word: syncs deasserted, output blanked.
   function automatic vga_ctrl_t vga_ctrl_idle(input logic sync_pol);
      vga_ctrl_t c;
      c.hsync = ~sync_pol;
      c.vsync = ~sync_pol;
      c.blank = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/vga_ctrl_delay.sv
// Shift register for hsync/vsync/blank so they line up with registered drawer RGB.
// DEPTH=0 is a straight wire; stages advance only on the pixel tick.
module vga_ctrl_delay
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = 1,
   parameter vga_ctrl_t   IDLE  = 3'b111
) (
   input  logic      clk_i,
   input  logic      reset_i,
   input  logic      ce_i,
   input  vga_ctrl_t ctrl_i,
   output vga_ctrl_t ctrl_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign ctrl_o = ctrl_i;
      end else begin : g_pipe
         vga_ctrl_t stage_q [DEPTH];

         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               for (int i = 0; i < int'(DEPTH); i++) begin
                  stage_q[i] <= IDLE;
               end
            end else if (ce_i) begin
               stage_q[0] <= ctrl_i;
               for (int i = 1; i < int'(DEPTH); i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign ctrl_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster counter: raw scan coordinates, frame event pulses and
// pipeline-aligned sync/blank for the maze/sprite drawers.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
   parameter int unsigned H_FP       = VGA_H_FP,
   parameter int unsigned H_SYNC     = VGA_H_SYNC,
   parameter int unsigned H_BP       = VGA_H_BP,
   parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
   parameter int unsigned V_FP       = VGA_V_FP,
   parameter int unsigned V_SYNC     = VGA_V_SYNC,
   parameter int unsigned V_BP       = VGA_V_BP,
   parameter logic        SYNC_POL   = 1'b0,
   parameter int unsigned PIPE_DEPTH = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pixel_ce,
   output logic [10:0] pixel_x,
   output logic [10:0] pixel_y,
   output logic        pixel_active,
   output logic        start_of_frame,
   output logic        end_of_active,
   output logic [7:0]  frame_cnt,
   output logic        hsync,
   output logic        vsync,
   output logic        blank
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [10:0] V_ACT_LAST   = 11'(V_ACTIVE - 1);
   localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
   localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] h_q, h_d;
   logic [10:0] v_q, v_d;
   logic [7:0]  frame_q, frame_d;
   logic        sof_q, sof_d;
   logic        eoa_q, eoa_d;
   logic        h_wrap, frame_wrap;
   vga_ctrl_t   ctrl_raw, ctrl_dly;

   always_comb begin
      h_wrap     = (h_q == H_LAST);
      frame_wrap = h_wrap && (v_q == V_LAST);
      h_d        = h_q;
      v_d        = v_q;
      frame_d    = frame_q;
      // Pulses are registered, so they appear the cycle after the causing tick.
      sof_d      = pixel_ce && frame_wrap;
      eoa_d      = pixel_ce && (h_q == H_ACT_LAST) && (v_q == V_ACT_LAST);
      if (pixel_ce) begin
         h_d = h_wrap ? 11'd0 : h_q + 11'd1;
         if (h_wrap) begin
            v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
         end
         if (frame_wrap) begin
            frame_d = frame_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= '0;
         sof_q   <= 1'b0;
         eoa_q   <= 1'b0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
         sof_q   <= sof_d;
         eoa_q   <= eoa_d;
      end
   end

   always_comb begin
      ctrl_raw.hsync = ((h_q >= H_SYNC_START) && (h_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      ctrl_raw.vsync = ((v_q >= V_SYNC_START) && (v_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      ctrl_raw.blank = ~pixel_active;
   end

   vga_ctrl_delay #(
      .DEPTH (PIPE_DEPTH),
      .IDLE  (vga_ctrl_idle(SYNC_POL))
   ) u_ctrl_delay (
      .clk_i   (clk),
      .reset_i (reset),
      .ce_i    (pixel_ce),
      .ctrl_i  (ctrl_raw),
      .ctrl_o  (ctrl_dly)
   );

   assign pixel_x        = h_q;
   assign pixel_y        = v_q;
   assign pixel_active   = (h_q < H_ACT_END) && (v_q < V_ACT_END);
   assign start_of_frame = sof_q;
   assign end_of_active  = eoa_q;
   assign frame_cnt      = frame_q;
   assign hsync          = ctrl_dly.hsync;
   assign vsync          = ctrl_dly.vsync;
   assign blank          = ctrl_dly.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance plus two scaled-down instances
// (pipe depth 1 and 3) checked cycle by cycle against a behavioural raster model.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic ce_a = 1'b0, rst_a = 1'b0, ce_b = 1'b0, rst_b = 1'b0;

   logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
   logic        act_a, sof_a, eoa_a, hs_a, vs_a, bl_a;
   logic        act_b, sof_b, eoa_b, hs_b, vs_b, bl_b;
   logic        act_c, sof_c, eoa_c, hs_c, vs_c, bl_c;
   logic [7:0]  fc_a, fc_b, fc_c;

   vga_timing_gen u_dut_a (
      .clk(clk), .reset(rst_a), .pixel_ce(ce_a), .pixel_x(x_a), .pixel_y(y_a),
      .pixel_active(act_a), .start_of_frame(sof_a), .end_of_active(eoa_a),
      .frame_cnt(fc_a), .hsync(hs_a), .vsync(vs_a), .blank(bl_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0), .PIPE_DEPTH(1)
   ) u_dut_b (
      .clk(clk), .reset(rst_b), .pixel_ce(ce_b), .pixel_x(x_b), .pixel_y(y_b),
      .pixel_active(act_b), .start_of_frame(sof_b), .end_of_active(eoa_b),
      .frame_cnt(fc_b), .hsync(hs_b), .vsync(vs_b), .blank(bl_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0), .PIPE_DEPTH(3)
   ) u_dut_c (
      .clk(clk), .reset(rst_b), .pixel_ce(ce_b), .pixel_x(x_c), .pixel_y(y_c),
      .pixel_active(act_c), .start_of_frame(sof_c), .end_of_active(eoa_c),
      .frame_cnt(fc_c), .hsync(hs_c), .vsync(vs_c), .blank(bl_c)
   );

   logic [35:0] obs_a, obs_b, obs_c;
   assign obs_a = {x_a, y_a, act_a, sof_a, eoa_a, fc_a, hs_a, vs_a, bl_a};
   assign obs_b = {x_b, y_b, act_b, sof_b, eoa_b, fc_b, hs_b, vs_b, bl_b};
   assign obs_c = {x_c, y_c, act_c, sof_c, eoa_c, fc_c, hs_c, vs_c, bl_c};

   // Model timing per instance: index 0 = default, 1 = scaled depth 1, 2 = scaled depth 3.
   int ha[3]  = '{640, 8, 8};
   int hfp[3] = '{16, 1, 1};
   int hsw[3] = '{96, 2, 2};
   int hbp[3] = '{48, 1, 1};
   int va[3]  = '{480, 4, 4};
   int vfp[3] = '{10, 1, 1};
   int vsw[3] = '{2, 1, 1};
   int vbp[3] = '{33, 1, 1};
   int pd[3]  = '{1, 1, 3};

   int          m_h[3], m_v[3], m_fc[3];
   bit          m_sof[3], m_eoa[3];
   logic [2:0]  m_dly[3][4];

   logic [35:0] exp_qa[$], exp_qb[$], exp_qc[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] ctrl_of(input int i, input int h, input int v);
      logic hs, vs, bl;
      hs = !((h >= ha[i] + hfp[i]) && (h < ha[i] + hfp[i] + hsw[i]));
      vs = !((v >= va[i] + vfp[i]) && (v < va[i] + vfp[i] + vsw[i]));
      bl = !((h < ha[i]) && (v < va[i]));
      return {hs, vs, bl};
   endfunction

   task automatic model_tick(input int i, input bit ce, input bit rst);
      int ht, vt;
      ht = ha[i] + hfp[i] + hsw[i] + hbp[i];
      vt = va[i] + vfp[i] + vsw[i] + vbp[i];
      if (rst) begin
         m_h[i] = 0; m_v[i] = 0; m_fc[i] = 0;
         m_sof[i] = 0; m_eoa[i] = 0;
         for (int k = 0; k < 4; k++) m_dly[i][k] = 3'b111;
      end else if (ce) begin
         m_sof[i] = (m_h[i] == ht - 1) && (m_v[i] == vt - 1);
         m_eoa[i] = (m_h[i] == ha[i] - 1) && (m_v[i] == va[i] - 1);
         if (m_sof[i]) m_fc[i] = (m_fc[i] + 1) % 256;
         for (int k = 3; k > 0; k--) m_dly[i][k] = m_dly[i][k-1];
         m_dly[i][0] = ctrl_of(i, m_h[i], m_v[i]);
         if (m_h[i] == ht - 1) begin
            m_h[i] = 0;
            m_v[i] = (m_v[i] == vt - 1) ? 0 : m_v[i] + 1;
         end else begin
            m_h[i] = m_h[i] + 1;
         end
      end else begin
         m_sof[i] = 0;
         m_eoa[i] = 0;
      end
   endtask

   function automatic logic [35:0] exp_pack(input int i);
      logic [2:0] ctl;
      logic       act;
      ctl = (pd[i] == 0) ? ctrl_of(i, m_h[i], m_v[i]) : m_dly[i][pd[i]-1];
      act = (m_h[i] < ha[i]) && (m_v[i] < va[i]);
      return {11'(m_h[i]), 11'(m_v[i]), act, m_sof[i], m_eoa[i], 8'(m_fc[i]), ctl};
   endfunction

   // One clock: drive inputs, push expectations, compare after the edge.
   task automatic step(input bit cea, input bit rsta, input bit ceb, input bit rstb);
      ce_a = cea; rst_a = rsta; ce_b = ceb; rst_b = rstb;
      model_tick(0, cea, rsta);
      model_tick(1, ceb, rstb);
      model_tick(2, ceb, rstb);
      exp_qa.push_back(exp_pack(0));
      exp_qb.push_back(exp_pack(1));
      exp_qc.push_back(exp_pack(2));
      @(posedge clk);
      #1;
      check_eq("cyc_a", 64'(obs_a), 64'(exp_qa.pop_front()));
      check_eq("cyc_b", 64'(obs_b), 64'(exp_qb.pop_front()));
      check_eq("cyc_c", 64'(obs_c), 64'(exp_qc.pop_front()));
   endtask

   int  hs_low, first_x, vs_low_b, vs_low_c, first_y, sof_n, eoa_n, eoa_x, eoa_y;
   int  hold_bad, wide, t0, t1, sof_seen;
   bit  saw_wrap, wrap_ok, prev_sof, prev_eoa, found, wrapped;
   logic [10:0] px, py;

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_h[i] = 0; m_v[i] = 0; m_fc[i] = 0; m_sof[i] = 0; m_eoa[i] = 0;
         for (int k = 0; k < 4; k++) m_dly[i][k] = 3'b111;
      end

      // Reset held for 3 clocks with the pixel tick running.
      for (int k = 0; k < 3; k++) step(1, 1, 1, 1);
      check_eq("rst_x", 64'(x_a), 64'(0));
      check_eq("rst_y", 64'(y_a), 64'(0));
      check_eq("rst_hsync", 64'(hs_a), 64'(1));
      check_eq("rst_vsync", 64'(vs_a), 64'(1));
      check_eq("rst_blank", 64'(bl_a), 64'(1));
      check_eq("rst_fc", 64'(fc_a), 64'(0));
      check_eq("rst_pulses", 64'({sof_a, eoa_a}), 64'(0));

      // One full line at default timing.
      hs_low = 0; first_x = -1; saw_wrap = 0; wrap_ok = 0;
      for (int k = 0; k < 810; k++) begin
         px = x_a; py = y_a;
         step(1, 0, 0, 0);
         if (hs_a == 1'b0) begin
            if (first_x < 0) first_x = int'(x_a);
            hs_low++;
         end
         if (px == 11'd799) begin
            saw_wrap = 1;
            wrap_ok  = (x_a == 11'd0) && (y_a == 11'd1) && (py == 11'd0);
         end
      end
      check_eq("hs_width", 64'(hs_low), 64'(96));
      check_eq("hs_first_x", 64'(first_x), 64'(657));
      check_eq("line_wrap", 64'({saw_wrap, wrap_ok}), 64'(2'b11));

      // Random pixel_ce on the default instance: everything holds when ce=0.
      hold_bad = 0;
      for (int k = 0; k < 400; k++) begin
         bit ce;
         ce = 1'($urandom_range(0, 1));
         px = x_a; py = y_a;
         step(ce, 0, 0, 0);
         if (!ce && ((x_a != px) || (y_a != py) || sof_a || eoa_a)) hold_bad++;
      end
      check_eq("ce_hold_a", 64'(hold_bad), 64'(0));

      // Scaled instances: one full frame from reset.
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      vs_low_b = 0; vs_low_c = 0; first_y = -1; sof_n = 0; eoa_n = 0; eoa_x = -1; eoa_y = -1;
      for (int k = 0; k < 100; k++) begin
         step(0, 0, 1, 0);
         if (vs_b == 1'b0) begin
            if (first_y < 0) first_y = int'(y_b);
            vs_low_b++;
         end
         if (vs_c == 1'b0) vs_low_c++;
         if (sof_b) sof_n++;
         if (eoa_b) begin
            eoa_n++; eoa_x = int'(x_b); eoa_y = int'(y_b);
         end
      end
      check_eq("sof_count", 64'(sof_n), 64'(1));
      check_eq("frame_cnt_1", 64'(fc_b), 64'(1));
      check_eq("vs_width_b", 64'(vs_low_b), 64'(12));
      check_eq("vs_width_c", 64'(vs_low_c), 64'(12));
      check_eq("vs_first_y", 64'(first_y), 64'(5));
      check_eq("eoa_count", 64'(eoa_n), 64'(1));
      check_eq("eoa_pos", 64'({eoa_x[10:0], eoa_y[10:0]}), 64'({11'd8, 11'd3}));

      // Alternating pixel_ce: a frame spans twice its tick count, pulses stay 1 clk.
      hold_bad = 0; wide = 0; sof_seen = 0; t0 = 0; t1 = 0; prev_sof = 0; prev_eoa = 0;
      for (int k = 0; k < 600 && sof_seen < 2; k++) begin
         bit ce;
         ce = (k % 2 == 0);
         px = x_b; py = y_b;
         step(0, 0, ce, 0);
         if (!ce && ((x_b != px) || (y_b != py) || sof_b || eoa_b)) hold_bad++;
         if ((sof_b && prev_sof) || (eoa_b && prev_eoa)) wide++;
         if (sof_b) begin
            if (sof_seen == 0) t0 = k; else t1 = k;
            sof_seen++;
         end
         prev_sof = sof_b; prev_eoa = eoa_b;
      end
      check_eq("frame_clks", 64'((sof_seen >= 2) ? (t1 - t0) : 0), 64'(168));
      check_eq("ce_hold_b", 64'(hold_bad), 64'(0));
      check_eq("pulse_width", 64'(wide), 64'(0));

      // Reset mid-frame at (5,2) with pixel_ce low.
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         step(0, 0, 1, 0);
         if (x_b == 11'd5 && y_b == 11'd2) found = 1;
      end
      check_eq("mid_pos_found", 64'(found), 64'(1));
      step(0, 0, 0, 1);
      check_eq("mid_rst_xy", 64'({x_b, y_b}), 64'(0));
      check_eq("mid_rst_blank", 64'(bl_b), 64'(1));
      check_eq("mid_rst_sof", 64'(sof_b), 64'(0));
      check_eq("mid_rst_fc", 64'(fc_b), 64'(0));

      // 256 frames: frame_cnt wraps 255 -> 0 on the 256th start_of_frame.
      sof_n = 0; wrapped = 0;
      for (int k = 0; k < 256 * 84 + 20 && !wrapped; k++) begin
         step(0, 0, 1, 0);
         if (sof_b) begin
            sof_n++;
            if (sof_n == 255) check_eq("fc_255", 64'(fc_b), 64'(255));
            if (sof_n == 256) begin
               check_eq("fc_wrap", 64'(fc_b), 64'(0));
               wrapped = 1;
            end
         end
      end
      check_eq("wrap_reached", 64'(wrapped), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
